// File: rtl/shim_cfg_pkg.sv
// Shared types and constants for the config-word crossing transmitter.
package shim_cfg_pkg;
  typedef enum logic {IDLE = 1'b0, WAIT_ACK = 1'b1} state_e;
  localparam int UPDATE_CNT_W    = 16;
  localparam int MIN_SYNC_STAGES = 2;
endpackage

// File: rtl/shim_bit_sync.sv
// N-stage single-bit synchronizer, async active-high reset to 0.
module shim_bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[STAGES-2:0], d};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];
endmodule

// File: rtl/shim_cfg_sync_tx.sv
// Transmitter half of a toggle-handshake config crossing: snapshots din,
// toggles xfer_req, waits for the synchronized ack toggle to match.
module shim_cfg_sync_tx
  import shim_cfg_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter int               SYNC_STAGES = 2,
  parameter int               TIMEOUT     = 1023,
  parameter logic [WIDTH-1:0] DEFAULT     = {WIDTH{1'b0}}
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [WIDTH-1:0]        din,
  input  logic                    resend,
  input  logic                    clear_timeout,
  output logic [WIDTH-1:0]        xfer_data,
  output logic                    xfer_req,
  input  logic                    xfer_ack_async,
  output logic                    busy,
  output logic                    ack_timeout,
  output logic [UPDATE_CNT_W-1:0] update_count
);
  localparam logic [15:0] TMO_MAX = 16'(TIMEOUT);
  localparam logic [15:0] TMO_PRE = 16'(TIMEOUT - 1);

  state_e                  state_q, state_d;
  logic [WIDTH-1:0]        xfer_data_q, xfer_data_d;
  logic                    xfer_req_q, xfer_req_d;
  logic                    force_pending_q, force_pending_d;
  logic [15:0]             tmo_cnt_q, tmo_cnt_d;
  logic                    ack_timeout_q, ack_timeout_d;
  logic [UPDATE_CNT_W-1:0] update_count_q, update_count_d;
  logic                    busy_q, busy_d;
  logic                    ack_sync;
  logic                    set_tmo;

  shim_bit_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk (aclk),
    .rst (areset),
    .d   (xfer_ack_async),
    .q   (ack_sync)
  );

  always_comb begin
    state_d         = state_q;
    xfer_data_d     = xfer_data_q;
    xfer_req_d      = xfer_req_q;
    force_pending_d = force_pending_q;
    tmo_cnt_d       = tmo_cnt_q;
    update_count_d  = update_count_q;
    ack_timeout_d   = ack_timeout_q;
    set_tmo         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if ((din != xfer_data_q) || force_pending_q || resend) begin
          xfer_data_d     = din;
          xfer_req_d      = ~xfer_req_q;
          force_pending_d = 1'b0;
          tmo_cnt_d       = '0;
          state_d         = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (resend) force_pending_d = 1'b1;
        if (tmo_cnt_q != TMO_MAX) tmo_cnt_d = tmo_cnt_q + 16'd1;
        // Flag only on the edge the counter reaches the limit, so a later lone clear sticks.
        if (tmo_cnt_q == TMO_PRE) set_tmo = 1'b1;
        if (ack_sync == xfer_req_q) begin
          state_d        = IDLE;
          update_count_d = update_count_q + 1'b1;
        end
      end
    endcase
    if (set_tmo)            ack_timeout_d = 1'b1;
    else if (clear_timeout) ack_timeout_d = 1'b0;
    busy_d = (state_d == WAIT_ACK);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q         <= IDLE;
      xfer_data_q     <= DEFAULT;
      xfer_req_q      <= 1'b0;
      force_pending_q <= 1'b1;
      tmo_cnt_q       <= '0;
      ack_timeout_q   <= 1'b0;
      update_count_q  <= '0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      xfer_data_q     <= xfer_data_d;
      xfer_req_q      <= xfer_req_d;
      force_pending_q <= force_pending_d;
      tmo_cnt_q       <= tmo_cnt_d;
      ack_timeout_q   <= ack_timeout_d;
      update_count_q  <= update_count_d;
      busy_q          <= busy_d;
    end
  end

  assign xfer_data    = xfer_data_q;
  assign xfer_req     = xfer_req_q;
  assign busy         = busy_q;
  assign ack_timeout  = ack_timeout_q;
  assign update_count = update_count_q;
endmodule

// File: tb/tb_shim_cfg_sync_tx.sv
// Directed bench for shim_cfg_sync_tx; a 3-cycle receiver echo returns xfer_req as the ack.
module tb_shim_cfg_sync_tx;
  logic        aclk = 1'b0;
  logic        areset;
  logic [31:0] din;
  logic        resend, clear_timeout;
  logic [31:0] xfer_data;
  logic        xfer_req, xfer_ack_async, busy, ack_timeout;
  logic [15:0] update_count;
  logic [2:0]  ack_pipe;
  logic        ack_hold;
  logic        saw22 = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;

  shim_cfg_sync_tx #(.WIDTH(32), .SYNC_STAGES(2), .TIMEOUT(16), .DEFAULT(32'h0)) dut (
    .aclk(aclk), .areset(areset), .din(din), .resend(resend),
    .clear_timeout(clear_timeout), .xfer_data(xfer_data), .xfer_req(xfer_req),
    .xfer_ack_async(xfer_ack_async), .busy(busy), .ack_timeout(ack_timeout),
    .update_count(update_count)
  );

  always #5 aclk = ~aclk;

  // Receiver model: echoes xfer_req three cycles later; ack_hold freezes it.
  always @(posedge aclk or posedge areset) begin
    if (areset)        ack_pipe <= 3'b000;
    else if (!ack_hold) ack_pipe <= {ack_pipe[1:0], xfer_req};
  end
  assign xfer_ack_async = ack_pipe[2];

  always @(negedge aclk) if (xfer_data == 32'h22) saw22 <= 1'b1;

  task automatic tick(input int n);
    repeat (n) @(negedge aclk);
  endtask

  task automatic test_reset;
    areset = 1'b1; din = '0; resend = 1'b0; clear_timeout = 1'b0; ack_hold = 1'b0;
    tick(3);
    n_cmp++; if (xfer_data !== 32'h0) begin n_bad++; $display("FAIL rst_data: got %h want %h", xfer_data, 32'h0); end
    n_cmp++; if (xfer_req !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %b want 0", xfer_req); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (ack_timeout !== 1'b0) begin n_bad++; $display("FAIL rst_tmo: got %b want 0", ack_timeout); end
    n_cmp++; if (update_count !== 16'h0) begin n_bad++; $display("FAIL rst_cnt: got %h want 0000", update_count); end
  endtask

  task automatic test_post_reset_push;
    areset = 1'b0;
    tick(1);
    n_cmp++; if (xfer_req !== 1'b1) begin n_bad++; $display("FAIL push_req: got %b want 1", xfer_req); end
    n_cmp++; if (xfer_data !== 32'h0) begin n_bad++; $display("FAIL push_data: got %h want %h", xfer_data, 32'h0); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL push_busy: got %b want 1", busy); end
    tick(5);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL push_busy5: got %b want 1", busy); end
    tick(1);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL push_done: got %b want 0", busy); end
    n_cmp++; if (update_count !== 16'd1) begin n_bad++; $display("FAIL push_cnt: got %h want 0001", update_count); end
  endtask

  task automatic test_single_update;
    din = 32'hA5;
    tick(1);
    n_cmp++; if (xfer_data !== 32'hA5) begin n_bad++; $display("FAIL upd_data: got %h want %h", xfer_data, 32'hA5); end
    n_cmp++; if (xfer_req !== 1'b0) begin n_bad++; $display("FAIL upd_req: got %b want 0", xfer_req); end
    tick(5);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL upd_busy5: got %b want 1", busy); end
    tick(1);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL upd_done: got %b want 0", busy); end
    n_cmp++; if (update_count !== 16'd2) begin n_bad++; $display("FAIL upd_cnt: got %h want 0002", update_count); end
  endtask

  task automatic test_coalesce;
    din = 32'h11;
    tick(1);
    n_cmp++; if (xfer_data !== 32'h11) begin n_bad++; $display("FAIL coal_first: got %h want %h", xfer_data, 32'h11); end
    tick(1); din = 32'h22;
    tick(1); din = 32'h33;
    tick(3);
    n_cmp++; if (xfer_data !== 32'h11) begin n_bad++; $display("FAIL coal_frozen: got %h want %h", xfer_data, 32'h11); end
    tick(1);
    n_cmp++; if (update_count !== 16'd3) begin n_bad++; $display("FAIL coal_cnt1: got %h want 0003", update_count); end
    tick(1);
    n_cmp++; if (xfer_data !== 32'h33) begin n_bad++; $display("FAIL coal_second: got %h want %h", xfer_data, 32'h33); end
    n_cmp++; if (xfer_req !== 1'b0) begin n_bad++; $display("FAIL coal_req: got %b want 0", xfer_req); end
    tick(6);
    n_cmp++; if (update_count !== 16'd4) begin n_bad++; $display("FAIL coal_cnt2: got %h want 0004", update_count); end
    n_cmp++; if (saw22 !== 1'b0) begin n_bad++; $display("FAIL coal_drop22: got %b want 0", saw22); end
  endtask

  task automatic test_resend;
    din = 32'h5A;
    tick(7);
    n_cmp++; if (update_count !== 16'd5) begin n_bad++; $display("FAIL rs_setup: got %h want 0005", update_count); end
    resend = 1'b1; tick(1); resend = 1'b0;
    n_cmp++; if (xfer_req !== 1'b0) begin n_bad++; $display("FAIL rs_idle_req: got %b want 0", xfer_req); end
    n_cmp++; if (xfer_data !== 32'h5A) begin n_bad++; $display("FAIL rs_idle_data: got %h want %h", xfer_data, 32'h5A); end
    tick(1); resend = 1'b1; tick(1); resend = 1'b0;
    tick(4);
    n_cmp++; if (update_count !== 16'd6) begin n_bad++; $display("FAIL rs_cnt6: got %h want 0006", update_count); end
    tick(1);
    n_cmp++; if (xfer_req !== 1'b1 || busy !== 1'b1) begin n_bad++; $display("FAIL rs_extra: got req=%b busy=%b want req=1 busy=1", xfer_req, busy); end
    tick(6);
    n_cmp++; if (update_count !== 16'd7) begin n_bad++; $display("FAIL rs_cnt7: got %h want 0007", update_count); end
  endtask

  task automatic test_timeout;
    ack_hold = 1'b1; din = 32'h77;
    tick(1);
    tick(15);
    n_cmp++; if (ack_timeout !== 1'b0) begin n_bad++; $display("FAIL tmo_early: got %b want 0", ack_timeout); end
    tick(1);
    n_cmp++; if (ack_timeout !== 1'b1 || busy !== 1'b1) begin n_bad++; $display("FAIL tmo_set: got tmo=%b busy=%b want 1 1", ack_timeout, busy); end
    ack_hold = 1'b0;
    tick(6);
    n_cmp++; if (busy !== 1'b0 || update_count !== 16'd8) begin n_bad++; $display("FAIL tmo_late_ack: got busy=%b cnt=%h want 0 0008", busy, update_count); end
    n_cmp++; if (ack_timeout !== 1'b1) begin n_bad++; $display("FAIL tmo_sticky: got %b want 1", ack_timeout); end
    ack_hold = 1'b1; din = 32'h78;
    tick(1);
    tick(15); clear_timeout = 1'b1;
    tick(1);  clear_timeout = 1'b0;
    n_cmp++; if (ack_timeout !== 1'b1) begin n_bad++; $display("FAIL tmo_set_wins: got %b want 1", ack_timeout); end
    clear_timeout = 1'b1; tick(1); clear_timeout = 1'b0;
    n_cmp++; if (ack_timeout !== 1'b0) begin n_bad++; $display("FAIL tmo_clear: got %b want 0", ack_timeout); end
    ack_hold = 1'b0;
    tick(6);
    n_cmp++; if (busy !== 1'b0 || update_count !== 16'd9 || ack_timeout !== 1'b0) begin n_bad++; $display("FAIL tmo_end: got busy=%b cnt=%h tmo=%b want 0 0009 0", busy, update_count, ack_timeout); end
  endtask

  task automatic test_reset_mid;
    din = 32'h99;
    tick(2);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy: got %b want 1", busy); end
    #2 areset = 1'b1;
    #1;
    n_cmp++; if (xfer_data !== 32'h0 || xfer_req !== 1'b0) begin n_bad++; $display("FAIL mid_data_req: got %h/%b want 0/0", xfer_data, xfer_req); end
    n_cmp++; if (busy !== 1'b0 || ack_timeout !== 1'b0 || update_count !== 16'h0) begin n_bad++; $display("FAIL mid_status: got busy=%b tmo=%b cnt=%h want 0 0 0000", busy, ack_timeout, update_count); end
    tick(2); areset = 1'b0;
    tick(1);
    n_cmp++; if (xfer_data !== 32'h99 || xfer_req !== 1'b1) begin n_bad++; $display("FAIL mid_repush: got %h/%b want 00000099/1", xfer_data, xfer_req); end
    tick(6);
    n_cmp++; if (update_count !== 16'd1) begin n_bad++; $display("FAIL mid_cnt: got %h want 0001", update_count); end
  endtask

  task automatic test_wrap;
    dut.update_count_q = 16'hFFFF;
    din = 32'hAB;
    tick(7);
    n_cmp++; if (update_count !== 16'h0000 || busy !== 1'b0) begin n_bad++; $display("FAIL wrap: got cnt=%h busy=%b want 0000 0", update_count, busy); end
  endtask

  initial begin
    test_reset;
    test_post_reset_push;
    test_single_update;
    test_coalesce;
    test_resend;
    test_timeout;
    test_reset_mid;
    test_wrap;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
